// File: rtl/cpu_intr_seq_pkg.sv
// Shared types and constants for the RP2A03 interrupt/reset sequencer.
// Holds the sequencer state and source encodings plus P-register bit indices.
package cpu_intr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUMMY1,
        ST_DUMMY2,
        ST_PUSH_PCH,
        ST_PUSH_PCL,
        ST_PUSH_P,
        ST_VEC_LO,
        ST_VEC_HI
    } intr_state_t;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_NMI   = 2'd1,
        SRC_BRK   = 2'd2,
        SRC_IRQ   = 2'd3
    } intr_src_t;

    localparam logic [2:0] VEC_OFS_NMI   = 3'd0;
    localparam logic [2:0] VEC_OFS_RESET = 3'd2;
    localparam logic [2:0] VEC_OFS_IRQ   = 3'd4;

    localparam int P_I = 2;
    localparam int P_B = 4;
    localparam int P_U = 5;

    function automatic logic [2:0] src_vec_ofs(input intr_src_t s);
        logic [2:0] ofs;
        ofs = VEC_OFS_IRQ;
        case (s)
            SRC_NMI:   ofs = VEC_OFS_NMI;
            SRC_RESET: ofs = VEC_OFS_RESET;
            default:   ofs = VEC_OFS_IRQ;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/nmi_edge_det.sv
// NMI falling-edge detector: keeps the previous nmi_n level and a pending
// flag that stays set until the sequencer clears it.
module nmi_edge_det (
    input  logic cpuClk,
    input  logic reset,
    input  logic nmi_n,
    input  logic clr,
    output logic pending
);

    logic r_nmi_q;

    // A new edge wins over a same-cycle clear so no NMI is ever dropped.
    always_ff @(posedge cpuClk) begin
        if (reset) begin
            r_nmi_q <= 1'b1;
            pending <= 1'b0;
        end else begin
            r_nmi_q <= nmi_n;
            if (r_nmi_q && !nmi_n) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_intr_seq.sv
// 6502 interrupt/reset entry sequencer: 7-cycle push/vector-fetch bus master.
// Optional NMI_HIJACK_EN lets a late NMI steal the vector of a BRK/IRQ entry.
module cpu_intr_seq
    import cpu_intr_seq_pkg::*;
#(
    parameter int               ADDR_W     = 16,
    parameter int               DATA_W     = 8,
    parameter int               NUM_IRQ    = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE  = 16'hFFFA,
    parameter logic [7:0]       STACK_PAGE = 8'h01
) (
    input  logic               cpuClk,
    input  logic               reset,
    input  logic               instr_boundary,
    input  logic               brk_req,
    input  logic               nmi_n,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               i_flag,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [7:0]         sp_in,
    input  logic [7:0]         p_in,
    input  logic [DATA_W-1:0]  dataRd,
    output logic [ADDR_W-1:0]  addr,
    output logic [DATA_W-1:0]  dataWr,
    output logic               wrEn,
    output logic               busy,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [7:0]         sp_out,
    output logic               done,
    output logic [1:0]         src
);

    intr_state_t       r_state;
    intr_src_t         r_src;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_sp;
    logic [7:0]        r_p;
    logic              r_brk;
    logic [DATA_W-1:0] r_vlo;

    logic              w_pend;
    logic              w_clr;
    logic              w_irq;
    logic              w_hijack;
    intr_src_t         w_src_vec;
    logic [ADDR_W-1:0] w_ret;
    logic [ADDR_W-1:0] w_vec;
    logic [7:0]        w_sp_dec;
    logic [7:0]        w_push_p;

    assign src = r_src;

    nmi_edge_det u_nmi (
        .cpuClk  (cpuClk),
        .reset   (reset),
        .nmi_n   (nmi_n),
        .clr     (w_clr),
        .pending (w_pend)
    );

`ifdef NMI_HIJACK_EN
    assign w_hijack = w_pend
                   && (r_src == SRC_BRK || r_src == SRC_IRQ)
                   && (r_state inside {ST_DUMMY1, ST_DUMMY2, ST_PUSH_PCH,
                                       ST_PUSH_PCL, ST_PUSH_P});
`else
    assign w_hijack = 1'b0;
`endif

    // Derived values: return address, pushed P, stack pointer step, vector.
    always_comb begin
        w_irq     = !i_flag && (|(~irq_n & irq_mask));
        w_ret     = r_brk ? r_pc + ADDR_W'(2) : r_pc;
        w_push_p  = r_p;
        w_push_p[P_U] = 1'b1;
        w_push_p[P_B] = r_brk;
        w_sp_dec  = r_sp - 8'd1;
        w_src_vec = w_hijack ? SRC_NMI : r_src;
        w_vec     = VEC_BASE + ADDR_W'(src_vec_ofs(w_src_vec));
        w_clr     = (r_state == ST_VEC_LO) && (r_src == SRC_NMI);
    end

    // Sequencer FSM; bus outputs are registered for the state being entered.
    always_ff @(posedge cpuClk) begin
        if (reset) begin
            r_state <= ST_DUMMY1;
            r_src   <= SRC_RESET;
            r_pc    <= pc_in;
            r_sp    <= sp_in;
            r_p     <= p_in;
            r_brk   <= 1'b0;
            r_vlo   <= '0;
            addr    <= '0;
            dataWr  <= '0;
            wrEn    <= 1'b0;
            busy    <= 1'b1;
            pc_out  <= '0;
            sp_out  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_hijack) begin
                r_src <= SRC_NMI;
            end
            unique case (r_state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    wrEn <= 1'b0;
                    if (instr_boundary && (w_pend || brk_req || w_irq)) begin
                        r_state <= ST_DUMMY1;
                        busy    <= 1'b1;
                        addr    <= pc_in;
                        r_pc    <= pc_in;
                        r_sp    <= sp_in;
                        r_p     <= p_in;
                        if (w_pend) begin
                            r_src <= SRC_NMI;
                            r_brk <= 1'b0;
                        end else if (brk_req) begin
                            r_src <= SRC_BRK;
                            r_brk <= 1'b1;
                        end else begin
                            r_src <= SRC_IRQ;
                            r_brk <= 1'b0;
                        end
                    end
                end
                ST_DUMMY1: begin
                    r_state <= ST_DUMMY2;
                    addr    <= r_pc;
                end
                ST_DUMMY2: begin
                    r_state <= ST_PUSH_PCH;
                    addr    <= ADDR_W'({STACK_PAGE, r_sp});
                    dataWr  <= DATA_W'(w_ret >> 8);
                    wrEn    <= (r_src != SRC_RESET);
                end
                ST_PUSH_PCH: begin
                    r_state <= ST_PUSH_PCL;
                    r_sp    <= w_sp_dec;
                    addr    <= ADDR_W'({STACK_PAGE, w_sp_dec});
                    dataWr  <= DATA_W'(w_ret);
                end
                ST_PUSH_PCL: begin
                    r_state <= ST_PUSH_P;
                    r_sp    <= w_sp_dec;
                    addr    <= ADDR_W'({STACK_PAGE, w_sp_dec});
                    dataWr  <= DATA_W'(w_push_p);
                end
                ST_PUSH_P: begin
                    r_state <= ST_VEC_LO;
                    r_sp    <= w_sp_dec;
                    addr    <= w_vec;
                    dataWr  <= '0;
                    wrEn    <= 1'b0;
                end
                ST_VEC_LO: begin
                    r_state <= ST_VEC_HI;
                    r_vlo   <= dataRd;
                    addr    <= w_vec + ADDR_W'(1);
                end
                ST_VEC_HI: begin
                    r_state <= ST_IDLE;
                    pc_out  <= ADDR_W'({dataRd, r_vlo});
                    sp_out  <= r_sp;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_intr_seq.sv
// Directed bench for cpu_intr_seq: reset, IRQ, BRK, NMI, masking,
// late-NMI behaviour (both builds of NMI_HIJACK_EN) and mid-sequence reset.
`timescale 1ns/1ps
module tb_cpu_intr_seq;

    typedef logic [24:0] bus_t;

    logic        cpuClk = 1'b0;
    logic        reset;
    logic        instr_boundary;
    logic        brk_req;
    logic        nmi_n;
    logic [3:0]  irq_n;
    logic [3:0]  irq_mask;
    logic        i_flag;
    logic [15:0] pc_in;
    logic [7:0]  sp_in;
    logic [7:0]  p_in;
    logic [7:0]  dataRd;
    logic [15:0] addr;
    logic [7:0]  dataWr;
    logic        wrEn;
    logic        busy;
    logic [15:0] pc_out;
    logic [7:0]  sp_out;
    logic        done;
    logic [1:0]  src;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic log_en = 1'b0;
    bus_t q_bus[$];

    always #5 cpuClk = ~cpuClk;

    cpu_intr_seq dut (
        .cpuClk         (cpuClk),
        .reset          (reset),
        .instr_boundary (instr_boundary),
        .brk_req        (brk_req),
        .nmi_n          (nmi_n),
        .irq_n          (irq_n),
        .irq_mask       (irq_mask),
        .i_flag         (i_flag),
        .pc_in          (pc_in),
        .sp_in          (sp_in),
        .p_in           (p_in),
        .dataRd         (dataRd),
        .addr           (addr),
        .dataWr         (dataWr),
        .wrEn           (wrEn),
        .busy           (busy),
        .pc_out         (pc_out),
        .sp_out         (sp_out),
        .done           (done),
        .src            (src)
    );

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        logic [7:0] d;
        case (a)
            16'hFFFA: d = 8'h00;
            16'hFFFB: d = 8'h90;
            16'hFFFC: d = 8'h00;
            16'hFFFD: d = 8'hC0;
            16'hFFFE: d = 8'h00;
            16'hFFFF: d = 8'h80;
            default:  d = 8'hEA;
        endcase
        return d;
    endfunction

    always_comb dataRd = mem_rd(addr);

    always @(posedge cpuClk) begin
        #1;
        if (log_en && busy)
            q_bus.push_back({wrEn, addr, wrEn ? dataWr : 8'h00});
    end

    function automatic bus_t R(input logic [15:0] a);
        return {1'b0, a, 8'h00};
    endfunction

    function automatic bus_t W(input logic [15:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    task automatic chk_log(input string tag, input bus_t exp[7]);
        chk({tag, "_len"}, q_bus.size(), 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("%s_cyc%0d", tag, i),
                (i < q_bus.size()) ? q_bus[i] : '1, exp[i]);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge cpuClk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic kick();
        instr_boundary = 1'b1;
        @(negedge cpuClk);
        instr_boundary = 1'b0;
        brk_req        = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        q_bus.delete();
        instr_boundary = 1'b1;
        repeat (6) @(negedge cpuClk);
        instr_boundary = 1'b0;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_nolog"}, q_bus.size(), 0);
    endtask

    initial begin
        reset = 1'b1; nmi_n = 1'b1; irq_n = 4'hF; irq_mask = 4'h0;
        i_flag = 1'b1; pc_in = 16'h0000; sp_in = 8'hFD; p_in = 8'h24;
        instr_boundary = 1'b0; brk_req = 1'b0;
        repeat (3) @(negedge cpuClk);
        chk("rst_addr", addr, 16'h0000);
        chk("rst_busy", busy, 1);
        chk("rst_wren", wrEn, 0);
        chk("rst_done", done, 0);
        chk("rst_src", src, 0);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_sp", sp_out, 8'h00);
        chk("rst_data", dataWr, 8'h00);

        // Reset sequence after release.
        log_en = 1'b1;
        @(negedge cpuClk);
        reset = 1'b0;
        wait_done("rs");
        chk_log("rs", '{R(16'h0000), R(16'h0000), R(16'h01FD), R(16'h01FC),
                        R(16'h01FB), R(16'hFFFC), R(16'hFFFD)});
        chk("rs_pc", pc_out, 16'hC000);
        chk("rs_sp", sp_out, 8'hFA);
        chk("rs_src", src, 0);

        // Level IRQ on channel 1.
        q_bus.delete();
        pc_in = 16'hC123; sp_in = 8'hFD; p_in = 8'h24;
        i_flag = 1'b0; irq_mask = 4'b0010; irq_n = 4'b1101;
        kick();
        wait_done("irq");
        chk_log("irq", '{R(16'hC123), R(16'hC123), W(16'h01FD, 8'hC1),
                         W(16'h01FC, 8'h23), W(16'h01FB, 8'h24),
                         R(16'hFFFE), R(16'hFFFF)});
        chk("irq_pc", pc_out, 16'h8000);
        chk("irq_sp", sp_out, 8'hFA);
        chk("irq_src", src, 3);

        // IRQ blocked by I flag, then by mask.
        i_flag = 1'b1;
        chk_idle("iflag");
        i_flag = 1'b0; irq_mask = 4'b0000;
        chk_idle("mask");
        irq_n = 4'hF;

        // BRK with stack wrap.
        q_bus.delete();
        pc_in = 16'hC123; sp_in = 8'h00; p_in = 8'h24; i_flag = 1'b1;
        brk_req = 1'b1;
        kick();
        wait_done("brk");
        chk_log("brk", '{R(16'hC123), R(16'hC123), W(16'h0100, 8'hC1),
                         W(16'h01FF, 8'h25), W(16'h01FE, 8'h34),
                         R(16'hFFFE), R(16'hFFFF)});
        chk("brk_pc", pc_out, 16'h8000);
        chk("brk_sp", sp_out, 8'hFD);
        chk("brk_src", src, 2);

        // NMI beats BRK and IRQ; second edge lands in VEC_HI.
        q_bus.delete();
        pc_in = 16'h8003; sp_in = 8'hFD; p_in = 8'h81; i_flag = 1'b0;
        irq_mask = 4'b0001; irq_n = 4'b1110; brk_req = 1'b1;
        nmi_n = 1'b0;
        @(negedge cpuClk);
        kick();
        nmi_n = 1'b1; irq_n = 4'hF;
        repeat (6) @(negedge cpuClk);
        chk("nmi_vechi_addr", addr, 16'hFFFB);
        nmi_n = 1'b0;
        wait_done("nmi");
        chk_log("nmi", '{R(16'h8003), R(16'h8003), W(16'h01FD, 8'h80),
                         W(16'h01FC, 8'h03), W(16'h01FB, 8'hA1),
                         R(16'hFFFA), R(16'hFFFB)});
        chk("nmi_pc", pc_out, 16'h9000);
        chk("nmi_sp", sp_out, 8'hFA);
        chk("nmi_src", src, 1);

        q_bus.delete();
        nmi_n = 1'b1; pc_in = 16'h9000; sp_in = 8'hFA; p_in = 8'h24;
        kick();
        wait_done("nmi2");
        chk_log("nmi2", '{R(16'h9000), R(16'h9000), W(16'h01FA, 8'h90),
                          W(16'h01F9, 8'h00), W(16'h01F8, 8'h24),
                          R(16'hFFFA), R(16'hFFFB)});
        chk("nmi2_sp", sp_out, 8'hF7);
        chk("nmi2_src", src, 1);
        chk_idle("nmiclr");

        // NMI edge during PUSH_PCL of an IRQ.
        q_bus.delete();
        pc_in = 16'hC123; sp_in = 8'hFD; p_in = 8'h24; i_flag = 1'b0;
        irq_mask = 4'b0010; irq_n = 4'b1101;
        kick();
        irq_n = 4'hF;
        repeat (3) @(negedge cpuClk);
        nmi_n = 1'b0;
        wait_done("hij");
`ifdef NMI_HIJACK_EN
        chk_log("hij", '{R(16'hC123), R(16'hC123), W(16'h01FD, 8'hC1),
                         W(16'h01FC, 8'h23), W(16'h01FB, 8'h24),
                         R(16'hFFFA), R(16'hFFFB)});
        chk("hij_pc", pc_out, 16'h9000);
        chk("hij_src", src, 1);
        nmi_n = 1'b1;
        chk_idle("hij_after");
`else
        chk_log("hij", '{R(16'hC123), R(16'hC123), W(16'h01FD, 8'hC1),
                         W(16'h01FC, 8'h23), W(16'h01FB, 8'h24),
                         R(16'hFFFE), R(16'hFFFF)});
        chk("hij_pc", pc_out, 16'h8000);
        chk("hij_src", src, 3);
        nmi_n = 1'b1; pc_in = 16'h8000; sp_in = 8'hFA;
        kick();
        wait_done("hij_nmi");
        chk("hij_nmi_pc", pc_out, 16'h9000);
        chk("hij_nmi_sp", sp_out, 8'hF7);
        chk("hij_nmi_src", src, 1);
`endif

        // Reset in the middle of a BRK with an NMI pending.
        log_en = 1'b0;
        q_bus.delete();
        pc_in = 16'hC123; sp_in = 8'hFD; brk_req = 1'b1;
        kick();
        @(negedge cpuClk);
        nmi_n = 1'b0;
        @(negedge cpuClk);
        reset = 1'b1; nmi_n = 1'b1; pc_in = 16'h0000; sp_in = 8'h10;
        log_en = 1'b1;
        @(negedge cpuClk);
        reset = 1'b0;
        wait_done("mid");
        chk_log("mid", '{R(16'h0000), R(16'h0000), R(16'h0110), R(16'h010F),
                         R(16'h010E), R(16'hFFFC), R(16'hFFFD)});
        chk("mid_pc", pc_out, 16'hC000);
        chk("mid_sp", sp_out, 8'h0D);
        chk("mid_src", src, 0);
        chk_idle("mid_clr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
